// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
// Checksum support is selected by IMEM_LOADER_CHECKSUM_EN in the users of this package.
package imem_loader_pkg;

    localparam int unsigned IMEM_DEPTH_W = 10;
    localparam int unsigned LEN_W        = 16;

    typedef enum logic [2:0] {
        StLenLo,
        StLenHi,
        StData,
        StCsum,
        StRun,
        StErr
    } state_e;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word_valid_o fires with the 4th byte.
module imem_word_assembler (
    input  logic        clk,
    input  logic        resetb,
    input  logic        clr_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] sh_q, sh_d;

    always_comb begin
        cnt_d        = cnt_q;
        sh_d         = sh_q;
        word_valid_o = 1'b0;
        word_o       = {byte_i, sh_q};
        if (clr_i) begin
            cnt_d = '0;
            sh_d  = '0;
        end else if (byte_valid_i) begin
            word_valid_o = (cnt_q == 2'd3);
            cnt_d        = cnt_q + 2'd1;
            // Newest byte enters at the top so byte 0 ends up in bits [7:0].
            sh_d         = {byte_i, sh_q[23:8]};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte image into instruction memory and holds the core in reset meanwhile.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_DEPTH_W
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_waddr,
    output logic [31:0]       im_wdata,
    output logic              core_resetb,
    output logic              busy,
    output logic              error
);

    localparam int unsigned Depth = 1 << ADDR_W;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]  wcnt_q, wcnt_d;
    logic               im_we_q, im_we_d;
    logic [ADDR_W-1:0]  im_waddr_q, im_waddr_d;
    logic [31:0]        im_wdata_q, im_wdata_d;
    logic               core_resetb_q, core_resetb_d;
    logic               accept, asm_clr, word_valid, last_word;
    logic [31:0]        word;
    logic [LEN_W-1:0]   len_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         acc_q, acc_d;
    logic [7:0]         sum_chk;
`endif

    assign in_ready = (state_q == StLenLo) || (state_q == StLenHi) ||
                      (state_q == StData)  || (state_q == StCsum);
    assign busy     = in_ready;
    assign error    = (state_q == StErr);
    assign accept   = in_valid && in_ready;

    assign len_full  = {in_data, len_q[7:0]};
    assign last_word = (32'(wcnt_q) == 32'(len_q) - 32'd1);

    imem_word_assembler u_asm (
        .clk          (clk),
        .resetb       (resetb),
        .clr_i        (asm_clr),
        .byte_valid_i (accept && (state_q == StData)),
        .byte_i       (in_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        wcnt_d     = wcnt_q;
        im_we_d    = 1'b0;
        im_waddr_d = im_waddr_q;
        im_wdata_d = im_wdata_q;
        asm_clr    = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        acc_d      = acc_q;
        sum_chk    = acc_q + in_data;
`endif
        case (state_q)
            StLenLo: begin
                if (accept) begin
                    len_d   = {8'h00, in_data};
                    state_d = StLenHi;
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_d = len_full;
                    if ((len_full == '0) || (32'(len_full) > Depth)) begin
                        state_d = StErr;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept) begin
                    acc_d = acc_q + in_data;
                end
`endif
                if (word_valid) begin
                    im_we_d    = 1'b1;
                    im_waddr_d = wcnt_q;
                    im_wdata_d = word;
                    wcnt_d     = wcnt_q + ADDR_W'(1);
                    if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = StCsum;
`else
                        state_d = StRun;
`endif
                    end
                end
            end
            StCsum: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept) begin
                    state_d = (sum_chk == 8'h00) ? StRun : StErr;
                end
`else
                state_d = StErr;
`endif
            end
            StRun, StErr: begin
                if (start) begin
                    state_d = StLenLo;
                    len_d   = '0;
                    wcnt_d  = '0;
                    asm_clr = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    acc_d   = '0;
`endif
                end
            end
            default: state_d = StLenLo;
        endcase
    end

    // Lags RUN entry by one edge so the final word lands before the core wakes.
    assign core_resetb_d = (state_q == StRun) && !start;

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q       <= StLenLo;
            len_q         <= '0;
            wcnt_q        <= '0;
            im_we_q       <= 1'b0;
            im_waddr_q    <= '0;
            im_wdata_q    <= '0;
            core_resetb_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            wcnt_q        <= wcnt_d;
            im_we_q       <= im_we_d;
            im_waddr_q    <= im_waddr_d;
            im_wdata_q    <= im_wdata_d;
            core_resetb_q <= core_resetb_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!resetb) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`endif

    assign im_we       = im_we_q;
    assign im_waddr    = im_waddr_q;
    assign im_wdata    = im_wdata_q;
    assign core_resetb = core_resetb_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; adapts to IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 10;

    logic              clk = 1'b0;
    logic              resetb;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_waddr;
    logic [31:0]       im_wdata;
    logic              core_resetb;
    logic              busy;
    logic              error;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] img [0:7];

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .resetb      (resetb),
        .start       (start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .im_we       (im_we),
        .im_waddr    (im_waddr),
        .im_wdata    (im_wdata),
        .core_resetb (core_resetb),
        .busy        (busy),
        .error       (error)
    );

    always #5 clk = ~clk;

    // Write log sampled mid-cycle; a one-cycle strobe is seen exactly once.
    always @(negedge clk) begin
        if (im_we) begin
            wr_addr.push_back(32'(im_waddr));
            wr_data.push_back(im_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetb   = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        resetb = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("ready_wait", 32'(in_ready), 32'd1);
        end else begin
            in_data  = b;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    // Sends length, img[0..nwords-1] and, when enabled, the checksum byte.
    task automatic send_image(input int nwords, input int max_gap);
        logic [7:0] sum = 8'h00;
        logic [7:0] b;
        send_byte(8'(nwords));
        send_byte(8'(nwords >> 8));
        for (int i = 0; i < 4 * nwords; i++) begin
            b = 8'(img[i / 4] >> (8 * (i % 4)));
            sum = sum + b;
            repeat ($urandom_range(max_gap, 0)) @(negedge clk);
            send_byte(b);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00 - sum);
`endif
    endtask

    task automatic check_writes(input string tag, input int n);
        check({tag, "_count"}, 32'(wr_addr.size()), 32'(n));
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_addr[i], 32'(i));
            check($sformatf("%s_data%0d", tag, i), wr_data[i], img[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetb   = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        do_reset();

        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_core", 32'(core_resetb), 32'd0);
        check("rst_we", 32'(im_we), 32'd0);
        check("rst_waddr", 32'(im_waddr), 32'd0);
        check("rst_wdata", im_wdata, 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);

        // Basic two-word load.
        clear_log();
        img[0] = 32'h0000_0013;
        img[1] = 32'h0100_006F;
        send_image(2, 0);
        check("t1_ready_run", 32'(in_ready), 32'd0);
        check("t1_core_held", 32'(core_resetb), 32'd0);
`ifndef IMEM_LOADER_CHECKSUM_EN
        check("t1_we_last", 32'(im_we), 32'd1);
        check("t1_waddr_last", 32'(im_waddr), 32'd1);
`endif
        @(posedge clk);
        #1;
        check("t1_core_rel", 32'(core_resetb), 32'd1);
        check("t1_we_off", 32'(im_we), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check_writes("t1", 2);

        // Restart from RUN with a second image.
        pulse_start();
        check("t6_core_fall", 32'(core_resetb), 32'd0);
        check("t6_ready", 32'(in_ready), 32'd1);
        clear_log();
        img[0] = 32'hDEAD_BEEF;
        send_image(1, 0);
        @(posedge clk);
        #1;
        check("t6_core_rel", 32'(core_resetb), 32'd1);
        check_writes("t6", 1);

        // Invalid lengths.
        do_reset();
        clear_log();
        send_byte(8'h00);
        send_byte(8'h00);
        check("t2_err0", 32'(error), 32'd1);
        check("t2_ready0", 32'(in_ready), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("t2_core0", 32'(core_resetb), 32'd0);
        check("t2_err0_hold", 32'(error), 32'd1);
        pulse_start();
        check("t2_err_clr", 32'(error), 32'd0);
        check("t2_ready_again", 32'(in_ready), 32'd1);
        send_byte(8'h01);
        send_byte(8'h04);
        check("t2_err401", 32'(error), 32'd1);
        check("t2_core401", 32'(core_resetb), 32'd0);
        check("t2_no_we", 32'(wr_addr.size()), 32'd0);
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h04);
        check("t2_len400_ok", 32'(error), 32'd0);
        check("t2_len400_busy", 32'(busy), 32'd1);

        // Four words with random in_valid gaps.
        do_reset();
        clear_log();
        img[0] = 32'h1122_3344;
        img[1] = 32'hA5A5_0F0F;
        img[2] = 32'h0000_0001;
        img[3] = 32'h8000_0000;
        send_image(4, 3);
        @(posedge clk);
        #1;
        check("t3_core_rel", 32'(core_resetb), 32'd1);
        repeat (10) @(posedge clk);
        check_writes("t3", 4);

        // Reset after 6 of 8 data bytes.
        do_reset();
        clear_log();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        @(negedge clk);
        resetb = 1'b0;
        @(posedge clk);
        #1;
        check("t5_we", 32'(im_we), 32'd0);
        check("t5_waddr", 32'(im_waddr), 32'd0);
        check("t5_wdata", im_wdata, 32'd0);
        check("t5_core", 32'(core_resetb), 32'd0);
        check("t5_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        resetb = 1'b1;
        img[0] = 32'h4433_2211;
        check_writes("t5", 1);
        clear_log();
        img[0] = 32'hDDCC_BBAA;
        send_image(1, 0);
        @(posedge clk);
        #1;
        check("t5_core_rel", 32'(core_resetb), 32'd1);
        check_writes("t5b", 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum pass and fail.
        do_reset();
        clear_log();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'hED);
        check("t4_ok_err", 32'(error), 32'd0);
        @(posedge clk);
        #1;
        check("t4_ok_core", 32'(core_resetb), 32'd1);
        do_reset();
        clear_log();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'hEC);
        check("t4_bad_err", 32'(error), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("t4_bad_core", 32'(core_resetb), 32'd0);
        img[0] = 32'h0000_0013;
        check_writes("t4", 1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory loader for the RV32I embedded softcore. Accepts a byte stream (from a UART receiver or debug port), assembles little-endian 32-bit words and writes them into the 1024-word instruction memory. Holds the core in reset during the load and releases it once the image is fully written. It takes over, in hardware, the program-load and hard-reset sequencing that the bench performs today.

## Interface
- `ADDR_W`, 10, instruction-memory word-address width; depth = 2^ADDR_W words.
- `clk` input 1 — system clock; all logic on rising edge.
- `resetb` input 1 — reset, synchronous, active-low.
- `start` input 1 — single-cycle pulse; restarts a load from RUN or ERR, ignored in other states.
- `in_data` input 8 — stream byte.
- `in_valid` input 1 — `in_data` valid.
- `in_ready` output 1 — loader can accept a byte; transfer occurs when `in_valid & in_ready` at a rising edge.
- `im_we` output 1 — instruction-memory write strobe, one cycle per word.
- `im_waddr` output ADDR_W — word address of the write.
- `im_wdata` output 32 — write data, byte 0 in bits [7:0].
- `core_resetb` output 1 — active-low reset to the core; low while loading.
- `busy` output 1 — high in LEN_LO, LEN_HI, DATA, CSUM.
- `error` output 1 — high in ERR.

## Operation
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4·N data bytes in little-endian word order, then one checksum byte (only with `IMEM_LOADER_CHECKSUM_EN`).
- States: LEN_LO → LEN_HI → DATA → [CSUM] → RUN; ERR on a fault.
- On reset: state LEN_LO, `core_resetb`=0, `im_we`=0, `im_waddr`=0, `im_wdata`=0, `error`=0, word and byte counters 0, checksum accumulator 0.
- `in_ready` = 1 in LEN_LO, LEN_HI, DATA, CSUM; 0 in RUN and ERR.
- LEN_HI accept: if N==0 or N>2^ADDR_W go to ERR, else DATA.
- DATA: byte counter 0..3 shifts bytes into the word register. The 4th byte registers `im_we`=1, `im_waddr`=word counter, and the completed word. The word counter then increments. After word N-1 go to CSUM, or to RUN when checksum is compiled out.
- `start` in RUN or ERR: go to LEN_LO, drive `core_resetb` low the next cycle, clear all counters, accumulator and `error`.
- `start` in any other state is ignored. No abort mid-load other than `resetb`.
- `resetb` low mid-load: immediate return to reset state. Memory words already written remain. No partial word is written.
- Words above N-1 are never written.

## Timing
- Data byte accepted at edge k completes word w: `im_we` high during cycle k..k+1, write occurs at edge k+1. Strobe width is exactly one cycle.
- Back-to-back words at full rate give one write every 4 cycles. `in_valid` gaps simply stall.
- Entry to RUN at edge k, which is the same edge that registers the final `im_we`.
- `core_resetb` is registered from (state==RUN) and rises at edge k+1. This guarantees the last word is written before the core leaves reset.
- ERR: `error` rises with state entry. `core_resetb` stays 0.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - CSUM state present; an 8-bit accumulator sums all data bytes mod 256 (length bytes excluded).
  - Checksum byte C is accepted in CSUM. If (sum + C) mod 256 == 0, go to RUN; else go to ERR.
- Not defined:
  - No CSUM state and no accumulator; the last data word goes straight to RUN.
  - ERR is reachable only via an invalid length.

## Structure
- Shared package `imem_loader_pkg`: state encoding (LEN_LO, LEN_HI, DATA, CSUM, RUN, ERR), `IMEM_DEPTH_W`=10, length-field width 16.
- One natural sub-module: `imem_word_assembler` — byte counter plus shift register, emitting `word_valid`/`word` on the 4th byte. The FSM, counters, checksum and reset output stay in the top.

## Test plan
- Load N=2: bytes 02 00 13 00 00 00 6F 00 00 01.
  - Two `im_we` pulses: addr 0 data 0x00000013, addr 1 data 0x0100006F.
  - `core_resetb` rises one cycle after the second write; `in_ready`=0 afterwards.
- Length 0x0000 or 0x0401 → ERR:
  - `error`=1, `core_resetb` stays 0, no `im_we`.
  - `start` then returns to LEN_LO with `error`=0.
- `in_valid` toggled randomly during N=4: same four writes with identical addr/data as the gapless run; no extra strobes.
- Checksum (macro on), N=1 data 13 00 00 00:
  - C=0xED → RUN.
  - C=0xEC → ERR with the word still written at addr 0.
- `resetb` asserted after 6 of 8 data bytes (N=2):
  - Only addr 0 written; outputs return to reset values.
  - A fresh stream then loads correctly.
- After RUN, pulse `start`:
  - `core_resetb` falls on the next cycle and `in_ready`=1.
  - A second image (N=1, 0xDEADBEEF) writes addr 0 and the core is released again.
